uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity encodings, transmitter states and parity helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Data is zero-extended to 9 bits; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered full/empty/count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Writes are gated by the registered full flag, so a same-cycle pop never frees a slot early.
    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_d   = (count_d == (AW+1)'(DEPTH));
        empty_d  = (count_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a TX FIFO
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          tx_hold,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          tx_serial
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   tx_done_q, tx_done_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   bit_end;
    logic                   can_start;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame sequencer: bit timing, state progression, FIFO pop and done pulse.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_done_d  = 1'b0;
        fifo_pop   = 1'b0;
        overflow_d = wr_en & fifo_full;
        bit_end    = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
        can_start  = ~fifo_empty & ~tx_hold;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                fifo_pop = can_start;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                        fifo_pop  = can_start;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop always launches a frame on the next cycle, from IDLE or straight out of STOP.
        if (fifo_pop) begin
            state_d    = ST_START;
            baud_cnt_d = '0;
            shift_d    = fifo_rdata;
            parity_d   = parity_bit(9'(fifo_rdata), PARITY_MODE);
        end
    end

    // Sequencer and pulse registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
        end
    end

    // Line level decoded from the current state; idle and stop are both high.
    always_comb begin
        tx_serial = 1'b1;
        case (state_q)
            ST_START:  tx_serial = 1'b0;
            ST_DATA:   tx_serial = shift_q[0];
            ST_PARITY: tx_serial = parity_q;
            default:   tx_serial = 1'b1;
        endcase
    end

    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = tx_done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    // 105 Hz / 10 baud truncates to 10 clocks per bit.
    localparam int TB_CPB = 10;
    localparam int NDUT   = 4;
    localparam int MAXS   = 2048;

    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic       PRESETn;
    logic       wr_en    [NDUT];
    logic [8:0] wr_data  [NDUT];
    logic       tx_hold  [NDUT];
    logic       ffull    [NDUT];
    logic       fempty   [NDUT];
    logic [4:0] fcnt     [NDUT];
    logic       ovf      [NDUT];
    logic       busy     [NDUT];
    logic       done     [NDUT];
    logic       ser      [NDUT];

    int cfg_bits [NDUT] = '{8, 8, 8, 7};
    int cfg_par  [NDUT] = '{0, 1, 2, 0};
    int cfg_stop [NDUT] = '{1, 1, 1, 2};

    int checks   = 0;
    int failures = 0;

    logic cap_ser  [MAXS];
    logic cap_done [MAXS];
    logic cap_busy [MAXS];

    uart_tx_fifo #(.CLK_FREQ(105), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_dflt (
        .PCLK(PCLK), .PRESETn(PRESETn), .wr_en(wr_en[0]), .wr_data(wr_data[0][7:0]),
        .tx_hold(tx_hold[0]), .fifo_full(ffull[0]), .fifo_empty(fempty[0]),
        .fifo_count(fcnt[0]), .overflow(ovf[0]), .tx_busy(busy[0]), .tx_done(done[0]),
        .tx_serial(ser[0]));

    uart_tx_fifo #(.CLK_FREQ(105), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(1),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
        .PCLK(PCLK), .PRESETn(PRESETn), .wr_en(wr_en[1]), .wr_data(wr_data[1][7:0]),
        .tx_hold(tx_hold[1]), .fifo_full(ffull[1]), .fifo_empty(fempty[1]),
        .fifo_count(fcnt[1]), .overflow(ovf[1]), .tx_busy(busy[1]), .tx_done(done[1]),
        .tx_serial(ser[1]));

    uart_tx_fifo #(.CLK_FREQ(105), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
        .PCLK(PCLK), .PRESETn(PRESETn), .wr_en(wr_en[2]), .wr_data(wr_data[2][7:0]),
        .tx_hold(tx_hold[2]), .fifo_full(ffull[2]), .fifo_empty(fempty[2]),
        .fifo_count(fcnt[2]), .overflow(ovf[2]), .tx_busy(busy[2]), .tx_done(done[2]),
        .tx_serial(ser[2]));

    uart_tx_fifo #(.CLK_FREQ(105), .BAUD_RATE(10), .DATA_BITS(7), .PARITY_MODE(0),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_7b2s (
        .PCLK(PCLK), .PRESETn(PRESETn), .wr_en(wr_en[3]), .wr_data(wr_data[3][6:0]),
        .tx_hold(tx_hold[3]), .fifo_full(ffull[3]), .fifo_empty(fempty[3]),
        .fifo_count(fcnt[3]), .overflow(ovf[3]), .tx_busy(busy[3]), .tx_done(done[3]),
        .tx_serial(ser[3]));

    function automatic int frame_len(input int d);
        return TB_CPB * (1 + cfg_bits[d] + ((cfg_par[d] != 0) ? 1 : 0) + cfg_stop[d]);
    endfunction

    function automatic logic [8:0] mask_data(input int d, input logic [8:0] data);
        logic [8:0] m;
        m = 9'((1 << cfg_bits[d]) - 1);
        return data & m;
    endfunction

    // Expected line level at clock offset 'off' from the start-bit edge.
    function automatic logic exp_level(input int d, input logic [8:0] data, input int off);
        int k;
        k = off / TB_CPB;
        if (k == 0) return 1'b0;
        if (k <= cfg_bits[d]) return data[k-1];
        if (cfg_par[d] == 1 && k == cfg_bits[d] + 1) return (($countones(data) % 2) == 1);
        if (cfg_par[d] == 2 && k == cfg_bits[d] + 1) return (($countones(data) % 2) == 0);
        return 1'b1;
    endfunction

    task automatic write_byte(input int d, input logic [8:0] data);
        @(posedge PCLK); #1;
        wr_en[d]   = 1'b1;
        wr_data[d] = data;
        @(posedge PCLK); #1;
        wr_en[d]   = 1'b0;
    endtask

    // Waits (bounded) for a falling edge on the line, then records n samples from it.
    task automatic capture(input int d, input int n, output bit found);
        logic prev;
        prev  = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 4000 && !found; w++) begin
            @(negedge PCLK);
            if (ser[d] === 1'b0 && prev === 1'b1) found = 1'b1;
            else prev = ser[d];
        end
        if (found) begin
            cap_ser[0] = ser[d]; cap_done[0] = done[d]; cap_busy[0] = busy[d];
            for (int i = 1; i < n; i++) begin
                @(negedge PCLK);
                cap_ser[i] = ser[d]; cap_done[i] = done[d]; cap_busy[i] = busy[d];
            end
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        #23;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({ser[d], busy[d], done[d], ovf[d], fcnt[d], fempty[d], ffull[d]} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_state dut%0d: ser=%b busy=%b done=%b ovf=%b cnt=%0d empty=%b full=%b",
                         d, ser[d], busy[d], done[d], ovf[d], fcnt[d], fempty[d], ffull[d]);
            end
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
    endtask

    task automatic test_single_frame(input int d, input logic [8:0] raw, input string tag);
        int L, bad;
        bit found;
        logic [8:0] data;
        data = mask_data(d, raw);
        L    = frame_len(d);
        write_byte(d, data);
        capture(d, L + 3, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s start: no start bit seen, want one within 4000 cycles", tag);
            return;
        end
        bad = -1;
        for (int i = 0; i < L + 3; i++)
            if (bad < 0 && cap_ser[i] !== exp_level(d, data, i)) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s line: sample %0d got %b want %b", tag, bad, cap_ser[bad],
                     exp_level(d, data, bad));
        end
        bad = -1;
        for (int i = 0; i < L + 3; i++)
            if (bad < 0 && cap_done[i] !== (i == L)) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s tx_done: sample %0d got %b want %b", tag, bad, cap_done[bad], (bad == L));
        end
        bad = -1;
        for (int i = 0; i < L + 3; i++)
            if (bad < 0 && cap_busy[i] !== (i < L)) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s tx_busy: sample %0d got %b want %b", tag, bad, cap_busy[bad], (bad < L));
        end
    endtask

    task automatic test_default_frame();
        int first_done;
        test_single_frame(0, 9'h0F, "dflt_0f");
        first_done = -1;
        for (int i = 0; i < 103; i++) if (first_done < 0 && cap_done[i] === 1'b1) first_done = i;
        checks++;
        if (first_done != 10 * TB_CPB) begin
            failures++;
            $display("FAIL dflt_done_latency: got %0d want %0d", first_done, 10 * TB_CPB);
        end
        for (int r = 0; r < 2; r++) test_single_frame(0, 9'($urandom_range(0, 255)), "dflt_rand");
    endtask

    task automatic test_parity();
        test_single_frame(1, 9'hCD, "even_cd");
        checks++;
        if (cap_ser[9 * TB_CPB + TB_CPB / 2] !== 1'b1) begin
            failures++;
            $display("FAIL even_cd_parity: got %b want 1", cap_ser[9 * TB_CPB + TB_CPB / 2]);
        end
        test_single_frame(2, 9'hEE, "odd_ee");
        checks++;
        if (cap_ser[9 * TB_CPB + TB_CPB / 2] !== 1'b1) begin
            failures++;
            $display("FAIL odd_ee_parity: got %b want 1", cap_ser[9 * TB_CPB + TB_CPB / 2]);
        end
        for (int r = 0; r < 3; r++) begin
            test_single_frame(1, 9'($urandom_range(0, 255)), "even_rand");
            test_single_frame(2, 9'($urandom_range(0, 255)), "odd_rand");
        end
    endtask

    task automatic test_data7_stop2();
        int first_done, hi;
        test_single_frame(3, 9'h55, "d7s2_55");
        first_done = -1;
        for (int i = 0; i < 103; i++) if (first_done < 0 && cap_done[i] === 1'b1) first_done = i;
        checks++;
        if (first_done != 10 * TB_CPB) begin
            failures++;
            $display("FAIL d7s2_frame_len: got %0d want %0d", first_done, 10 * TB_CPB);
        end
        hi = 0;
        for (int i = 8 * TB_CPB; i < 10 * TB_CPB; i++) if (cap_ser[i] === 1'b1) hi++;
        checks++;
        if (hi != 2 * TB_CPB) begin
            failures++;
            $display("FAIL d7s2_stop_high: got %0d want %0d", hi, 2 * TB_CPB);
        end
        test_single_frame(3, 9'($urandom_range(0, 127)), "d7s2_rand");
    endtask

    task automatic test_back_to_back();
        logic [8:0] q[$];
        int ov, L, n, bad, ndone;
        bit found;
        logic e_ser, e_done;
        L  = frame_len(0);
        ov = 0;
        @(posedge PCLK); #1;
        tx_hold[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge PCLK); #1;
            wr_en[0]   = 1'b1;
            wr_data[0] = 9'($urandom_range(0, 255));
            if (i < 16) q.push_back(wr_data[0]);
            @(negedge PCLK);
            if (ovf[0] === 1'b1) ov++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            wr_en[0] = 1'b0;
            @(negedge PCLK);
            if (ovf[0] === 1'b1) ov++;
        end
        checks++;
        if (ov != 1) begin failures++; $display("FAIL burst_overflow_pulses: got %0d want 1", ov); end
        checks++;
        if (ffull[0] !== 1'b1) begin failures++; $display("FAIL burst_full: got %b want 1", ffull[0]); end
        checks++;
        if (fcnt[0] !== 5'd16) begin failures++; $display("FAIL burst_count: got %0d want 16", fcnt[0]); end
        @(posedge PCLK); #1;
        tx_hold[0] = 1'b0;
        n = 16 * L + 5;
        capture(0, n, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL burst_start: no start bit seen, want one within 4000 cycles");
            return;
        end
        bad   = -1;
        ndone = 0;
        for (int i = 0; i < n; i++) begin
            e_ser  = (i < 16 * L) ? exp_level(0, q[i / L], i % L) : 1'b1;
            e_done = (i > 0 && i <= 16 * L && (i % L) == 0);
            if (bad < 0 && (cap_ser[i] !== e_ser || cap_done[i] !== e_done)) bad = i;
            if (cap_done[i] === 1'b1) ndone++;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL burst_stream: sample %0d got ser=%b done=%b want ser=%b done=%b", bad,
                     cap_ser[bad], cap_done[bad],
                     (bad < 16 * L) ? exp_level(0, q[bad / L], bad % L) : 1'b1,
                     (bad > 0 && bad <= 16 * L && (bad % L) == 0));
        end
        checks++;
        if (ndone != 16) begin failures++; $display("FAIL burst_done_count: got %0d want 16", ndone); end
        checks++;
        if (fempty[0] !== 1'b1 || fcnt[0] !== 5'd0) begin
            failures++;
            $display("FAIL burst_drained: got empty=%b cnt=%0d want empty=1 cnt=0", fempty[0], fcnt[0]);
        end
    endtask

    task automatic test_hold_mid_frame();
        logic [8:0] a, b;
        int L, bad, starts;
        bit found;
        logic prev;
        L = frame_len(0);
        a = 9'($urandom_range(0, 255));
        b = 9'($urandom_range(0, 255));
        @(posedge PCLK); #1; wr_en[0] = 1'b1; wr_data[0] = a;
        @(posedge PCLK); #1; wr_data[0] = b;
        @(posedge PCLK); #1; wr_en[0] = 1'b0;
        fork
            capture(0, L + 3, found);
            begin
                repeat (40) @(posedge PCLK);
                #1 tx_hold[0] = 1'b1;
            end
        join
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL hold_start: no start bit seen, want one within 4000 cycles");
            return;
        end
        bad = -1;
        for (int i = 0; i < L + 3; i++)
            if (bad < 0 && (cap_ser[i] !== exp_level(0, a, i) || cap_done[i] !== (i == L))) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL hold_frame_completes: sample %0d got ser=%b done=%b want ser=%b done=%b",
                     bad, cap_ser[bad], cap_done[bad], exp_level(0, a, bad), (bad == L));
        end
        starts = 0;
        prev   = 1'b1;
        for (int i = 0; i < 3 * L; i++) begin
            @(negedge PCLK);
            if (ser[0] !== 1'b1 || busy[0] !== 1'b0) starts++;
            prev = ser[0];
        end
        checks++;
        if (starts != 0) begin
            failures++;
            $display("FAIL hold_blocks_start: got %0d active samples want 0 (last ser=%b)", starts, prev);
        end
        checks++;
        if (fcnt[0] !== 5'd1) begin failures++; $display("FAIL hold_count: got %0d want 1", fcnt[0]); end
        @(posedge PCLK); #1;
        tx_hold[0] = 1'b0;
        capture(0, L + 3, found);
        bad = found ? -1 : 0;
        for (int i = 0; found && i < L + 3; i++)
            if (bad < 0 && cap_ser[i] !== exp_level(0, b, i)) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL hold_release_frame: found=%b first bad sample %0d want clean frame of %h", found, bad, b);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] a, b;
        int L, bad;
        bit found;
        L = frame_len(0);
        a = 9'($urandom_range(0, 255)) & 9'h0F7;
        b = 9'($urandom_range(0, 255));
        @(posedge PCLK); #1; wr_en[0] = 1'b1; wr_data[0] = a;
        @(posedge PCLK); #1; wr_data[0] = b;
        @(posedge PCLK); #1; wr_en[0] = 1'b0;
        capture(0, 4 * TB_CPB + TB_CPB / 2 + 1, found);
        checks++;
        if (!found || cap_ser[4 * TB_CPB + TB_CPB / 2] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_bit3_before: found=%b got %b want 0", found, cap_ser[4 * TB_CPB + TB_CPB / 2]);
        end
        checks++;
        if (fcnt[0] !== 5'd1) begin failures++; $display("FAIL rst_mid_count_before: got %0d want 1", fcnt[0]); end
        #3 PRESETn = 1'b0;
        #1;
        checks++;
        if (ser[0] !== 1'b1 || fcnt[0] !== 5'd0 || busy[0] !== 1'b0 || fempty[0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_async: got ser=%b cnt=%0d busy=%b empty=%b want 1 0 0 1",
                     ser[0], fcnt[0], busy[0], fempty[0]);
        end
        #22 PRESETn = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * L; i++) begin
            @(negedge PCLK);
            if (done[0] !== 1'b0 || ser[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_mid_after_release: got %0d samples with done/line activity want 0", bad);
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            wr_en[d]   = 1'b0;
            wr_data[d] = '0;
            tx_hold[d] = 1'b0;
        end
        test_reset();
        test_default_frame();
        test_parity();
        test_data7_stop2();
        test_back_to_back();
        test_hold_mid_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
